fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter, instruction-register and memory-data-register stage of the multi-cycle CPU. It turns the Controller's `PCWrite`, `PCWriteCond`, `PCSource`, `IorD`, `MemRead`, `MemWrite` and `IRWrite` strobes into memory requests and PC updates. It also feeds `OpCode` and `Funct` back to the Controller from the latched instruction. Architectural registers sit here; the ALU and register file stay outside.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`  in  1 each  Controller strobes.
- `PCSource`  in  2  next-PC select.
- `alu_result`  in  32  combinational ALU output of the current cycle.
- `alu_zero`  in  1  ALU zero flag of the current cycle.
- `rs_data`  in  32  register-file read port A, used for `jr`/`jalr`.
- `rt_data`  in  32  register-file read port B, used as store data.
- `mem_rdata`  in  32  memory read data; combinational in address.
- `mem_addr`  out  32  memory address: PC when `IorD`=0, `alu_out` when `IorD`=1.
- `mem_wdata`  out  32  equals `rt_data`.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `pc`, `instr`, `mdr`, `alu_out`  out  32 each  registered PC, IR, MDR and ALUOut.
- `OpCode`, `Funct`  out  6 each  `instr[31:26]`, `instr[5:0]`.
- `addr_misaligned`  out  1  sticky misaligned-access flag.
- `instr_count`, `cycle_count`  out  32 each  performance counters.

## Operation
- Reset values:
  - `pc`=`RESET_PC`.
  - `instr`, `mdr`, `alu_out`, both counters = 0.
  - `addr_misaligned`=0.
  - `mem_read`=`mem_write`=0 while `reset` is high.
- `alu_out` loads `alu_result` every cycle unconditionally.
- `mdr` loads `mem_rdata` on every edge where `mem_read`=1.
- `instr` loads `mem_rdata` when `IRWrite`=1 and `IorD`=0. `IRWrite` with `IorD`=1 is ignored.
- `mem_write`=`MemWrite`. `mem_read`=`MemRead & ~MemWrite`, so a write wins over a simultaneous read.
- PC update enable is `PCWrite | (PCWriteCond & alu_zero)`. When both `PCWrite` and `PCWriteCond` are high, `PCWrite` governs.
- Next-PC by `PCSource`:
  - 00: `alu_result` (PC+4).
  - 01: `alu_out` (branch target).
  - 10: jump target, resolved by `OpCode`:
    - `j`/`jal` (0x02/0x03): `{pc[31:28], instr[25:0], 2'b00}`.
    - R-type (0x00): `rs_data`.
    - any other opcode: PC holds.
  - 11: `rs_data`.
- `addr_misaligned` sets when `mem_read|mem_write` is high and `mem_addr[1:0]`≠0. It clears only on reset. The access itself still proceeds.
- `instr_count` increments on each edge where `instr` loads.
- `cycle_count` increments every cycle out of reset.
- Both counters wrap at 2^32.

## Timing
- All registers update on the same edge as the strobe that enables them.
- IR, PC and MDR values are visible the cycle after the strobe.
- Fetch: `MemRead`=`IRWrite`=`PCWrite`=1 with `PCSource`=00 in one cycle loads `instr`=mem[PC] and `pc`=PC+4 on the same edge.
- `OpCode`/`Funct` change only when `instr` loads. Decode always sees a stable value for the whole following cycle.
- Memory write commits on the edge where `mem_write`=1, using that cycle's `mem_addr`/`mem_wdata`.
- Reset asserted mid-instruction immediately forces the reset values and drops `mem_write` combinationally. No partial write completes after the reset edge.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (`lw`, `sw`, `beq`, `j`, `jal`, R-type).
  - funct constants (`jr`, `jalr`).
  - `PCSource` encodings `PCSRC_SEQ`/`PCSRC_BR`/`PCSRC_JMP`/`PCSRC_REG`.
  - reset-PC default.
- One sub-module, `pc_next_mux`: purely combinational next-PC select plus the PC update-enable logic.

## Test plan
- Fetch with mem[0]=0x2008_0005, `alu_result`=4, fetch strobes high → next cycle `instr`=0x2008_0005, `pc`=4, `OpCode`=0x08, `instr_count`=1.
- `beq`, `PCWriteCond`=1, `PCSource`=01, `alu_out`=0x40:
  - `alu_zero`=0 → `pc` unchanged.
  - `alu_zero`=1 → `pc`=0x40.
- `j` with `instr`=0x0800_0010, `pc`=0x1000_0008, `PCWrite`=1, `PCSource`=10 → `pc`=0x1000_0040.
- `jr`: R-type `instr`, `rs_data`=0x0000_0100, `PCSource`=10 → `pc`=0x100. Same stimulus with opcode `lw` → `pc` holds.
- Store: `IorD`=1, `alu_out`=0x22, `MemWrite`=`MemRead`=1 →
  - `mem_write`=1, `mem_read`=0, `mem_addr`=0x22.
  - `addr_misaligned` sets and stays 1 after `MemWrite` drops.
- Assert `reset` during a `MemWrite` cycle → `mem_write` drops the same cycle; `pc`=`RESET_PC`; counters=0; flag cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU: opcodes, funct codes, PCSource
// encodings and the reset program counter.
package cpu_pkg;

  localparam int          DATA_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JMP = 2'b10,
    PCSRC_REG = 2'b11
  } pcsrc_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select and PC update enable.
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs_data,
  input  pcsrc_e      pc_source,
  input  logic        alu_zero,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  output logic [31:0] pc_next,
  output logic        pc_en
);

  logic [5:0] opcode;

  always_comb begin
    opcode  = instr[31:26];
    pc_en   = pc_write | (pc_write_cond & alu_zero);
    pc_next = pc;
    unique case (pc_source)
      PCSRC_SEQ: pc_next = alu_result;
      PCSRC_BR:  pc_next = alu_out;
      PCSRC_JMP: begin
        // Jump target depends on the latched instruction; unknown opcodes hold PC
        if (opcode == OP_J || opcode == OP_JAL)
          pc_next = {pc[31:28], instr[25:0], 2'b00};
        else if (opcode == OP_RTYPE)
          pc_next = rs_data;
        else
          pc_next = pc;
      end
      PCSRC_REG: pc_next = rs_data;
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC, IR, MDR and ALUOut registers of the multi-cycle CPU, plus memory
// request generation, misaligned-access flag and performance counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [1:0]  PCSource,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic [31:0] alu_out,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        addr_misaligned,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] ir_d, ir_q;
  logic [31:0] mdr_d, mdr_q;
  logic [31:0] alu_out_d, alu_out_q;
  logic [31:0] icnt_d, icnt_q;
  logic [31:0] ccnt_d, ccnt_q;
  logic        misalign_d, misalign_q;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        ir_load;

  pc_next_mux u_pc_next_mux (
    .pc            (pc_q),
    .instr         (ir_q),
    .alu_result    (alu_result),
    .alu_out       (alu_out_q),
    .rs_data       (rs_data),
    .pc_source     (pcsrc_e'(PCSource)),
    .alu_zero      (alu_zero),
    .pc_write      (PCWrite),
    .pc_write_cond (PCWriteCond),
    .pc_next       (pc_next),
    .pc_en         (pc_en)
  );

  // Strobes are gated by reset so no access can straddle the reset edge
  always_comb begin
    mem_write = MemWrite & ~reset;
    mem_read  = MemRead & ~MemWrite & ~reset;
    mem_addr  = IorD ? alu_out_q : pc_q;
    mem_wdata = rt_data;
    ir_load   = IRWrite & ~IorD;
  end

  always_comb begin
    pc_d       = pc_en ? pc_next : pc_q;
    ir_d       = ir_load ? mem_rdata : ir_q;
    mdr_d      = mem_read ? mem_rdata : mdr_q;
    alu_out_d  = alu_result;
    icnt_d     = ir_load ? icnt_q + 32'd1 : icnt_q;
    ccnt_d     = ccnt_q + 32'd1;
    misalign_d = misalign_q | ((mem_read | mem_write) & (mem_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mdr_q      <= '0;
      alu_out_q  <= '0;
      icnt_q     <= '0;
      ccnt_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      alu_out_q  <= alu_out_d;
      icnt_q     <= icnt_d;
      ccnt_q     <= ccnt_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    pc              = pc_q;
    instr           = ir_q;
    mdr             = mdr_q;
    alu_out         = alu_out_q;
    OpCode          = ir_q[31:26];
    Funct           = ir_q[5:0];
    addr_misaligned = misalign_q;
    instr_count     = icnt_q;
    cycle_count     = ccnt_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard testbench for fetch_unit with a small behavioural memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  PCSource;
  logic [31:0] alu_result, rs_data, rt_data, mem_rdata;
  logic        alu_zero;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr, alu_out, instr_count, cycle_count;
  logic        mem_read, mem_write, addr_misaligned;
  logic [5:0]  OpCode, Funct;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          checks = 0;
  int          errors = 0;
  int          exp_cyc = 0;
  int          exp_icnt = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCSource(PCSource), .alu_result(alu_result), .alu_zero(alu_zero),
    .rs_data(rs_data), .rt_data(rt_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .pc(pc), .instr(instr), .mdr(mdr), .alu_out(alu_out),
    .OpCode(OpCode), .Funct(Funct), .addr_misaligned(addr_misaligned),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    if (!reset) exp_cyc++;
    #1;
  endtask

  task automatic idle();
    PCWrite = 0; PCWriteCond = 0; IorD = 0; MemRead = 0; MemWrite = 0;
    IRWrite = 0; PCSource = 2'b00; alu_zero = 0;
  endtask

  task automatic test_reset();
    idle();
    alu_result = 0; rs_data = 0; rt_data = 0;
    reset = 1;
    pre_we = 1;
    for (int i = 0; i < 256; i++) begin
      pre_addr = i[7:0];
      case (i)
        0:       pre_data = 32'h2008_0005;
        2:       pre_data = 32'h0800_0010;
        12:      pre_data = 32'h0000_1111;
        16:      pre_data = 32'h03E0_0008;
        64:      pre_data = 32'h8C0A_0004;
        default: pre_data = 32'h0;
      endcase
      step();
    end
    pre_we = 0;
    MemRead = 1; MemWrite = 1;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (pc !== e) begin errors++; $display("FAIL reset_pc got %h want %h", pc, e); end
    e = exp_q.pop_front(); checks++;
    if (instr !== e) begin errors++; $display("FAIL reset_instr got %h want %h", instr, e); end
    e = exp_q.pop_front(); checks++;
    if (cycle_count !== e) begin errors++; $display("FAIL reset_ccnt got %h want %h", cycle_count, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, mem_write} !== e) begin errors++; $display("FAIL reset_mem_write got %h want %h", mem_write, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, mem_read} !== e) begin errors++; $display("FAIL reset_mem_read got %h want %h", mem_read, e); end
    idle();
    step();
    reset = 0;
  endtask

  task automatic test_fetch();
    MemRead = 1; IRWrite = 1; PCWrite = 1; PCSource = 2'b00; alu_result = 32'd4;
    exp_q.push_back(32'h2008_0005); exp_q.push_back(32'd4);
    exp_q.push_back(32'h08); exp_q.push_back(32'h2008_0005);
    exp_icnt++;
    step();
    idle();
    e = exp_q.pop_front(); checks++;
    if (instr !== e) begin errors++; $display("FAIL fetch_instr got %h want %h", instr, e); end
    e = exp_q.pop_front(); checks++;
    if (pc !== e) begin errors++; $display("FAIL fetch_pc got %h want %h", pc, e); end
    e = exp_q.pop_front(); checks++;
    if ({26'b0, OpCode} !== e) begin errors++; $display("FAIL fetch_opcode got %h want %h", OpCode, e); end
    e = exp_q.pop_front(); checks++;
    if (mdr !== e) begin errors++; $display("FAIL fetch_mdr got %h want %h", mdr, e); end
    checks++;
    if (instr_count !== exp_icnt) begin errors++; $display("FAIL fetch_icnt got %0d want %0d", instr_count, exp_icnt); end
    checks++;
    if (cycle_count !== exp_cyc) begin errors++; $display("FAIL fetch_ccnt got %0d want %0d", cycle_count, exp_cyc); end
  endtask

  task automatic test_branch();
    alu_result = 32'h40;
    step();
    PCWriteCond = 1; PCSource = 2'b01; alu_zero = 0;
    exp_q.push_back(32'd4);
    step();
    e = exp_q.pop_front(); checks++;
    if (pc !== e) begin errors++; $display("FAIL beq_not_taken got %h want %h", pc, e); end
    alu_zero = 1;
    exp_q.push_back(32'h40);
    step();
    idle();
    e = exp_q.pop_front(); checks++;
    if (pc !== e) begin errors++; $display("FAIL beq_taken got %h want %h", pc, e); end
  endtask

  task automatic test_jump();
    PCWrite = 1; PCSource = 2'b11; rs_data = 32'h1000_0008;
    step();
    idle();
    MemRead = 1; IRWrite = 1;
    exp_icnt++;
    step();
    idle();
    exp_q.push_back(32'h0800_0010);
    e = exp_q.pop_front(); checks++;
    if (instr !== e) begin errors++; $display("FAIL j_instr got %h want %h", instr, e); end
    PCWrite = 1; PCSource = 2'b10;
    exp_q.push_back(32'h1000_0040);
    step();
    idle();
    e = exp_q.pop_front(); checks++;
    if (pc !== e) begin errors++; $display("FAIL j_target got %h want %h", pc, e); end
  endtask

  task automatic test_jr();
    MemRead = 1; IRWrite = 1;
    exp_icnt++;
    step();
    idle();
    rs_data = 32'h100; PCWrite = 1; PCSource = 2'b10;
    exp_q.push_back(32'h100);
    step();
    idle();
    e = exp_q.pop_front(); checks++;
    if (pc !== e) begin errors++; $display("FAIL jr_target got %h want %h", pc, e); end
    MemRead = 1; IRWrite = 1;
    exp_icnt++;
    step();
    idle();
    exp_q.push_back(32'h23);
    e = exp_q.pop_front(); checks++;
    if ({26'b0, OpCode} !== e) begin errors++; $display("FAIL lw_opcode got %h want %h", OpCode, e); end
    rs_data = 32'h200; PCWrite = 1; PCSource = 2'b10;
    exp_q.push_back(32'h100);
    step();
    idle();
    e = exp_q.pop_front(); checks++;
    if (pc !== e) begin errors++; $display("FAIL lw_jmp_hold got %h want %h", pc, e); end
    // IRWrite with IorD=1 must not touch the IR or the instruction counter
    alu_result = 32'h0;
    step();
    IRWrite = 1; IorD = 1; MemRead = 1;
    exp_q.push_back(32'h8C0A_0004);
    step();
    idle();
    e = exp_q.pop_front(); checks++;
    if (instr !== e) begin errors++; $display("FAIL ir_iord_ignored got %h want %h", instr, e); end
    checks++;
    if (instr_count !== exp_icnt) begin errors++; $display("FAIL jr_icnt got %0d want %0d", instr_count, exp_icnt); end
  endtask

  task automatic test_store();
    logic [31:0] mdr_before;
    alu_result = 32'h22;
    step();
    mdr_before = mdr;
    IorD = 1; MemWrite = 1; MemRead = 1; rt_data = 32'h0000_CAFE;
    #1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h22);
    e = exp_q.pop_front(); checks++;
    if ({31'b0, mem_write} !== e) begin errors++; $display("FAIL st_mem_write got %h want %h", mem_write, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, mem_read} !== e) begin errors++; $display("FAIL st_mem_read got %h want %h", mem_read, e); end
    e = exp_q.pop_front(); checks++;
    if (mem_addr !== e) begin errors++; $display("FAIL st_mem_addr got %h want %h", mem_addr, e); end
    step();
    idle();
    checks++;
    if (addr_misaligned !== 1'b1) begin errors++; $display("FAIL st_misaligned got %b want 1", addr_misaligned); end
    checks++;
    if (mem[8] !== 32'h0000_CAFE) begin errors++; $display("FAIL st_commit got %h want 0000cafe", mem[8]); end
    checks++;
    if (mdr !== mdr_before) begin errors++; $display("FAIL st_mdr_hold got %h want %h", mdr, mdr_before); end
    step();
    checks++;
    if (addr_misaligned !== 1'b1) begin errors++; $display("FAIL st_misaligned_sticky got %b want 1", addr_misaligned); end
    checks++;
    if (cycle_count !== exp_cyc) begin errors++; $display("FAIL st_ccnt got %0d want %0d", cycle_count, exp_cyc); end
  endtask

  task automatic test_reset_mid_write();
    alu_result = 32'h30;
    step();
    IorD = 1; MemWrite = 1; rt_data = 32'h0000_DEAD;
    #2;
    reset = 1;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %b want 0", mem_write); end
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 00000000", pc); end
    checks++;
    if (instr_count !== 32'h0 || cycle_count !== 32'h0)
      begin errors++; $display("FAIL rst_counters got %h/%h want 0/0", instr_count, cycle_count); end
    checks++;
    if (addr_misaligned !== 1'b0) begin errors++; $display("FAIL rst_flag got %b want 0", addr_misaligned); end
    step();
    checks++;
    if (mem[12] !== 32'h0000_1111) begin errors++; $display("FAIL rst_no_write got %h want 00001111", mem[12]); end
    idle();
    reset = 0;
    exp_cyc = 0;
    step();
    checks++;
    if (cycle_count !== exp_cyc) begin errors++; $display("FAIL rst_ccnt_restart got %0d want %0d", cycle_count, exp_cyc); end
  endtask

  initial begin
    pre_we = 0; pre_addr = 0; pre_data = 0;
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_jr();
    test_store();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
